// File: rtl/pm_multibank_rw_if.sv
// pm_multibank_rw_if: CPU-side bus bundle for pm_multibank_rw.
// wp_bank_max/wp_err exist only when PM_WPROT_EN is defined.
interface pm_multibank_rw_if #(parameter int BANK_W = 8, parameter int ADDR_W = 8);
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] romaddr;
  logic [ADDR_W-1:0] ramaddr;
  logic [3:0] din;
  logic [3:0] opa;
  logic we;
  logic re;
  logic fl_clr;
  logic [7:0] dout;
  logic [3:0] rdata;
  logic rvalid;
  logic fl;
`ifdef PM_WPROT_EN
  logic [BANK_W-1:0] wp_bank_max;
  logic wp_err;
`endif
  modport master (
    output bank, romaddr, ramaddr, din, opa, we, re, fl_clr,
    input dout, rdata, rvalid, fl
`ifdef PM_WPROT_EN
    , output wp_bank_max, input wp_err
`endif
  );
  modport slave (
    input bank, romaddr, ramaddr, din, opa, we, re, fl_clr,
    output dout, rdata, rvalid, fl
`ifdef PM_WPROT_EN
    , input wp_bank_max, output wp_err
`endif
  );
endinterface

// File: rtl/pm_multibank_rw.sv
// pm_multibank_rw: banked program RAM with registered fetch, atomic two-nibble WPM and nibble RPM.
// Optional bank write protection when PM_WPROT_EN is defined.
module pm_multibank_rw #(
  parameter int BANK_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [3:0] OPC_WPM = 4'h3,
  parameter logic [3:0] OPC_RPM = 4'hA
) (
  input logic clk,
  input logic reset_n,
  pm_multibank_rw_if.slave bus
);
  localparam int AW = BANK_W + ADDR_W;
  typedef enum logic {LO, HI} fl_t;
  fl_t st, st_nxt;
  logic [7:0] mem [2**AW];
  logic [3:0] lo, lo_nxt;
  logic [AW-1:0] waddr, waddr_nxt;
  logic wpm, rpm, wr_en, prot;
  logic [7:0] rbyte;
  always_comb begin
    wpm = !bus.fl_clr && bus.we && bus.opa == OPC_WPM;
    rpm = !bus.fl_clr && !wpm && bus.re && bus.opa == OPC_RPM;
`ifdef PM_WPROT_EN
    prot = bus.wp_bank_max != '0 && waddr[AW-1:ADDR_W] <= bus.wp_bank_max;
`else
    prot = 1'b0;
`endif
    st_nxt = bus.fl_clr ? LO : (wpm || rpm) ? ((st == LO) ? HI : LO) : st;
    lo_nxt = bus.fl_clr ? 4'h0 : (wpm && st == LO) ? bus.din : lo;
    waddr_nxt = (wpm && st == LO) ? {bus.bank, bus.ramaddr} : waddr;
    wr_en = wpm && st == HI && !prot;
    rbyte = mem[{bus.bank, bus.ramaddr}];
  end
  // RAM is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk)
    if (wr_en) mem[waddr] <= {bus.din, lo};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= LO;
      lo <= '0;
      waddr <= '0;
      bus.dout <= '0;
      bus.rdata <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      st <= st_nxt;
      lo <= lo_nxt;
      waddr <= waddr_nxt;
      bus.dout <= mem[{bus.bank, bus.romaddr}];
      bus.rdata <= rpm ? ((st == HI) ? rbyte[7:4] : rbyte[3:0]) : bus.rdata;
      bus.rvalid <= rpm;
    end
`ifdef PM_WPROT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bus.wp_err <= 1'b0;
    else bus.wp_err <= wpm && st == HI && prot;
`endif
  assign bus.fl = st == HI;
endmodule

// File: tb/tb_pm_multibank_rw.sv
// tb_pm_multibank_rw: scoreboard bench for pm_multibank_rw; RPM nibbles are queued at issue and popped on rvalid.
module tb_pm_multibank_rw;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_nib;
  pm_multibank_rw_if #(.BANK_W(8), .ADDR_W(8)) bus ();
  pm_multibank_rw dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  always @(negedge clk)
    if (reset_n && bus.rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: rdata=%h, no read outstanding", bus.rdata);
      end else begin
        exp_nib = exp_q.pop_front();
        if (bus.rdata !== exp_nib) begin
          errors++;
          $display("FAIL rpm_rdata: got %h expected %h", bus.rdata, exp_nib);
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.we = 1'b0;
    bus.re = 1'b0;
    bus.fl_clr = 1'b0;
    bus.opa = 4'h0;
  endtask
  task automatic wpm(input logic [7:0] b, input logic [7:0] a, input logic [3:0] d);
    bus.bank = b;
    bus.ramaddr = a;
    bus.din = d;
    bus.opa = 4'h3;
    bus.we = 1'b1;
    tick();
    idle();
  endtask
  task automatic rpm(input logic [7:0] b, input logic [7:0] a, input logic [3:0] e);
    exp_q.push_back(e);
    bus.bank = b;
    bus.ramaddr = a;
    bus.opa = 4'hA;
    bus.re = 1'b1;
    tick();
    idle();
  endtask
  task automatic fetch(input logic [7:0] b, input logic [7:0] a);
    bus.bank = b;
    bus.romaddr = a;
    tick();
  endtask
  task automatic test_reset();
    idle();
    bus.bank = '0;
    bus.romaddr = '0;
    bus.ramaddr = '0;
    bus.din = '0;
`ifdef PM_WPROT_EN
    bus.wp_bank_max = '0;
`endif
    #23;
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
    checks++; if (bus.rdata !== 4'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid); end
    checks++; if (bus.fl !== 1'b0) begin errors++; $display("FAIL reset_fl: got %b expected 0", bus.fl); end
    #4 reset_n = 1'b1;
    tick();
  endtask
  task automatic test_wpm();
    wpm(8'h02, 8'h11, 4'hC);
    wpm(8'h02, 8'h11, 4'h3);
    wpm(8'h02, 8'h10, 4'h5);
    checks++; if (bus.fl !== 1'b1) begin errors++; $display("FAIL wpm_fl_after_lo: got %b expected 1", bus.fl); end
    wpm(8'h02, 8'h11, 4'hA);
    checks++; if (bus.fl !== 1'b0) begin errors++; $display("FAIL wpm_fl_after_hi: got %b expected 0", bus.fl); end
    fetch(8'h02, 8'h10);
    checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL wpm_fetch_0210: got %h expected a5", bus.dout); end
    fetch(8'h02, 8'h11);
    checks++; if (bus.dout !== 8'h3C) begin errors++; $display("FAIL wpm_fetch_0211: got %h expected 3c", bus.dout); end
  endtask
  task automatic test_rpm();
    rpm(8'h02, 8'h10, 4'h5);
    checks++; if (bus.fl !== 1'b1) begin errors++; $display("FAIL rpm_fl_first: got %b expected 1", bus.fl); end
    rpm(8'h02, 8'h10, 4'hA);
    checks++; if (bus.fl !== 1'b0) begin errors++; $display("FAIL rpm_fl_second: got %b expected 0", bus.fl); end
    tick();
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rpm_rvalid_pulse: got %b expected 0", bus.rvalid); end
  endtask
  task automatic test_back_to_back();
    wpm(8'h02, 8'h20, 4'h1);
    wpm(8'h02, 8'h20, 4'h1);
    bus.romaddr = 8'h20;
    wpm(8'h02, 8'h20, 4'hE);
    wpm(8'h02, 8'h20, 4'h7);
    checks++; if (bus.dout !== 8'h11) begin errors++; $display("FAIL b2b_read_first: got %h expected 11", bus.dout); end
    rpm(8'h02, 8'h20, 4'hE);
    checks++; if (bus.dout !== 8'h7E) begin errors++; $display("FAIL b2b_fetch_new: got %h expected 7e", bus.dout); end
    rpm(8'h02, 8'h20, 4'h7);
    checks++; if (bus.fl !== 1'b0) begin errors++; $display("FAIL b2b_fl: got %b expected 0", bus.fl); end
  endtask
  task automatic test_fl_clr();
    wpm(8'h02, 8'h30, 4'h9);
    checks++; if (bus.fl !== 1'b1) begin errors++; $display("FAIL flclr_fl_pre: got %b expected 1", bus.fl); end
    bus.fl_clr = 1'b1;
    bus.we = 1'b1;
    bus.opa = 4'h3;
    bus.din = 4'hF;
    tick();
    idle();
    checks++; if (bus.fl !== 1'b0) begin errors++; $display("FAIL flclr_fl: got %b expected 0", bus.fl); end
    wpm(8'h02, 8'h30, 4'h3);
    wpm(8'h02, 8'h30, 4'hC);
    fetch(8'h02, 8'h30);
    checks++; if (bus.dout !== 8'hC3) begin errors++; $display("FAIL flclr_byte: got %h expected c3", bus.dout); end
  endtask
  task automatic test_simultaneous();
    bus.bank = 8'h02;
    bus.ramaddr = 8'h40;
    bus.opa = 4'h3;
    bus.we = 1'b1;
    bus.re = 1'b1;
    bus.din = 4'h6;
    tick();
    checks++; if (bus.fl !== 1'b1 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL sim_wpm_lo: fl=%b rvalid=%b expected fl=1 rvalid=0", bus.fl, bus.rvalid); end
    bus.din = 4'h7;
    tick();
    idle();
    checks++; if (bus.fl !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL sim_wpm_hi: fl=%b rvalid=%b expected fl=0 rvalid=0", bus.fl, bus.rvalid); end
    fetch(8'h02, 8'h40);
    checks++; if (bus.dout !== 8'h76) begin errors++; $display("FAIL sim_byte: got %h expected 76", bus.dout); end
    exp_q.push_back(4'h6);
    bus.opa = 4'hA;
    bus.we = 1'b1;
    bus.re = 1'b1;
    tick();
    idle();
    checks++; if (bus.fl !== 1'b1) begin errors++; $display("FAIL sim_rpm_fl: got %b expected 1", bus.fl); end
    rpm(8'h02, 8'h40, 4'h7);
    bus.opa = 4'hA;
    bus.we = 1'b1;
    tick();
    idle();
    checks++; if (bus.fl !== 1'b0) begin errors++; $display("FAIL we_wrong_opa: fl=%b expected 0", bus.fl); end
    bus.opa = 4'h3;
    bus.re = 1'b1;
    tick();
    idle();
    checks++; if (bus.fl !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL re_wrong_opa: fl=%b rvalid=%b expected 0 0", bus.fl, bus.rvalid); end
  endtask
  task automatic test_reset_mid_pair();
    bus.romaddr = 8'h10;
    wpm(8'h02, 8'h10, 4'hE);
    checks++; if (bus.fl !== 1'b1 || bus.dout !== 8'hA5) begin errors++; $display("FAIL midrst_pre: fl=%b dout=%h expected 1 a5", bus.fl, bus.dout); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (bus.fl !== 1'b0 || bus.dout !== 8'h00 || bus.rdata !== 4'h0) begin errors++; $display("FAIL midrst_async: fl=%b dout=%h rdata=%h expected 0 00 0", bus.fl, bus.dout, bus.rdata); end
    #2 reset_n = 1'b1;
    fetch(8'h02, 8'h10);
    checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL midrst_retained: got %h expected a5", bus.dout); end
    rpm(8'h02, 8'h10, 4'h5);
    rpm(8'h02, 8'h10, 4'hA);
  endtask
`ifdef PM_WPROT_EN
  task automatic test_wprot();
    wpm(8'h03, 8'h50, 4'h2);
    wpm(8'h03, 8'h50, 4'h1);
    bus.wp_bank_max = 8'h03;
    wpm(8'h03, 8'h50, 4'hF);
    wpm(8'h03, 8'h50, 4'hE);
    checks++; if (bus.wp_err !== 1'b1 || bus.fl !== 1'b0) begin errors++; $display("FAIL wp_block: wp_err=%b fl=%b expected 1 0", bus.wp_err, bus.fl); end
    fetch(8'h03, 8'h50);
    checks++; if (bus.wp_err !== 1'b0 || bus.dout !== 8'h12) begin errors++; $display("FAIL wp_kept: wp_err=%b dout=%h expected 0 12", bus.wp_err, bus.dout); end
    wpm(8'h04, 8'h50, 4'hF);
    wpm(8'h04, 8'h50, 4'hE);
    checks++; if (bus.wp_err !== 1'b0) begin errors++; $display("FAIL wp_allow_err: got %b expected 0", bus.wp_err); end
    fetch(8'h04, 8'h50);
    checks++; if (bus.dout !== 8'hEF) begin errors++; $display("FAIL wp_allow_byte: got %h expected ef", bus.dout); end
    bus.wp_bank_max = '0;
  endtask
`endif
  initial begin
    test_reset();
    test_wpm();
    test_rpm();
    test_back_to_back();
    test_fl_clr();
    test_simultaneous();
    test_reset_mid_pair();
`ifdef PM_WPROT_EN
    test_wprot();
`endif
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rpm_outstanding: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
